// File: rtl/spi_periph_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_periph_pkg
// Purpose  : Shared widths, counts and the FSM state type for the SPI
//            amplifier/ADC responder and its synchronizers.
// Revision : 1.0 - initial release
// ============================================================================
package spi_periph_pkg;

    localparam int SAMPLE_W      = 14;   // bits per ADC channel sample
    localparam int GAIN_W        = 8;    // amplifier gain word width
    localparam int FRAME_LEN     = 34;   // SPI_CLK falling edges per ADC frame
    localparam int GAIN_BITS_REQ = 8;    // bits a well-formed gain write carries
    localparam int CNT_W         = 6;    // shared bit counter width

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        AMP_SHIFT = 2'd1,
        ADC_FRAME = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_amp_adc_responder_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Purpose  : Two-flop synchronizer for one asynchronous input, followed by an
//            edge flop that produces registered single-clk rise/fall strobes.
// Ports    : clk   - system clock
//            rst   - asynchronous active-low reset
//            din   - asynchronous input pin
//            level - synchronized level, aligned with the strobes
//            rise  - one-clk pulse, 3 clk after a 0->1 pin transition
//            fall  - one-clk pulse, 3 clk after a 1->0 pin transition
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise   <= sync_q & ~prev_q;
            fall   <= ~sync_q & prev_q;
        end
    end

    // prev_q is one clk behind sync_q, so it lines up in time with the
    // registered strobes; data sampled on a strobe uses this delayed copy.
    assign level = prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_amp_adc_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_amp_adc_responder
// Purpose  : Peripheral side of the preamp/ADC SPI link. Accepts 8-bit gain
//            words on MOSI while AMP_CS is low, and on each ADC_Conv pulse
//            serializes Ch0/Ch1 onto MISO in a 34-clock frame.
// Ports    : clk        - system clock, all logic on rising edge
//            rst        - asynchronous active-low reset
//            SPI_CLK    - serial clock from controller (async to clk)
//            MOSI       - serial data from controller
//            AMP_CS     - amplifier select, active-low
//            ADC_Conv   - conversion start, active-high pulse
//            Ch0, Ch1   - parallel sample sources
//            MISO       - serial data to controller
//            Gain       - last accepted gain word
//            Gain_Valid - one-clk pulse when Gain updates
//            Gain_Err   - one-clk pulse on a malformed gain write
//            Busy       - high while a gain write or ADC frame is running
// Revision : 1.0 - initial release
// ============================================================================
module spi_amp_adc_responder #(
    parameter int SAMPLE_W  = spi_periph_pkg::SAMPLE_W,
    parameter int GAIN_W    = spi_periph_pkg::GAIN_W,
    parameter int FRAME_LEN = spi_periph_pkg::FRAME_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                SPI_CLK,
    input  logic                MOSI,
    input  logic                AMP_CS,
    input  logic                ADC_Conv,
    input  logic [SAMPLE_W-1:0] Ch0,
    input  logic [SAMPLE_W-1:0] Ch1,
    output logic                MISO,
    output logic [GAIN_W-1:0]   Gain,
    output logic                Gain_Valid,
    output logic                Gain_Err,
    output logic                Busy
);

    import spi_periph_pkg::*;

    // Frame layout: 2 zero bits, Ch0, 2 zero bits, Ch1, 2 zero bits.
    localparam int FRAME_W = 2 * SAMPLE_W + 6;
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] GAIN_CNT   = CNT_W'(GAIN_BITS_REQ);
    localparam logic [CNT_W-1:0] GAIN_SAT   = CNT_W'(GAIN_BITS_REQ + 1);

    // ------------------------------------------------------------------
    // Input synchronization and edge detection
    // ------------------------------------------------------------------
    logic sclk_rise;
    logic sclk_fall;
    logic mosi_lvl;
    logic cs_rise;
    logic cs_fall;
    logic conv_rise;

    logic unused_sclk_lvl;
    logic unused_mosi_rise;
    logic unused_mosi_fall;
    logic unused_cs_lvl;
    logic unused_conv_lvl;
    logic unused_conv_fall;

    sync_edge u_sync_sclk (
        .clk   (clk),
        .rst   (rst),
        .din   (SPI_CLK),
        .level (unused_sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge u_sync_mosi (
        .clk   (clk),
        .rst   (rst),
        .din   (MOSI),
        .level (mosi_lvl),
        .rise  (unused_mosi_rise),
        .fall  (unused_mosi_fall)
    );

    sync_edge u_sync_cs (
        .clk   (clk),
        .rst   (rst),
        .din   (AMP_CS),
        .level (unused_cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    sync_edge u_sync_conv (
        .clk   (clk),
        .rst   (rst),
        .din   (ADC_Conv),
        .level (unused_conv_lvl),
        .rise  (conv_rise),
        .fall  (unused_conv_fall)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    state_t state;
    state_t state_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    logic [GAIN_W-1:0]  gain_sr;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] frame_sr;

    logic start_amp;
    logic amp_shift;
    logic amp_end;
    logic start_adc;
    logic adc_adv;

    always_comb begin
        state_next = state;
        start_amp  = 1'b0;
        amp_shift  = 1'b0;
        amp_end    = 1'b0;
        start_adc  = 1'b0;
        adc_adv    = 1'b0;

        case (state)
            IDLE: begin
                // A select fall outranks a conversion arriving in the same clk.
                if (cs_fall) begin
                    state_next = AMP_SHIFT;
                    start_amp  = 1'b1;
                end else if (conv_rise) begin
                    state_next = ADC_FRAME;
                    start_adc  = 1'b1;
                end
            end
            AMP_SHIFT: begin
                // Deselect closes the write even if a clock edge coincides.
                if (cs_rise) begin
                    state_next = IDLE;
                    amp_end    = 1'b1;
                end else if (sclk_rise) begin
                    amp_shift = 1'b1;
                end
            end
            ADC_FRAME: begin
                // AMP_CS and ADC_Conv activity is ignored until the frame ends.
                if (sclk_fall) begin
                    if (bit_cnt == FRAME_LAST) begin
                        state_next = IDLE;
                    end else begin
                        adc_adv = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift registers, counter and gain output
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gain_sr    <= '0;
            bit_cnt    <= '0;
            frame_sr   <= '0;
            Gain       <= '0;
            Gain_Valid <= 1'b0;
            Gain_Err   <= 1'b0;
        end else begin
            Gain_Valid <= 1'b0;
            Gain_Err   <= 1'b0;

            if (start_amp) begin
                gain_sr <= '0;
                bit_cnt <= '0;
            end

            if (amp_shift) begin
                gain_sr <= {gain_sr[GAIN_W-2:0], mosi_lvl};
                // Saturating one past the legal count keeps over-long
                // writes distinguishable from exact ones.
                if (bit_cnt != GAIN_SAT) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (amp_end) begin
                if (bit_cnt == GAIN_CNT) begin
                    Gain       <= gain_sr;
                    Gain_Valid <= 1'b1;
                end else begin
                    Gain_Err   <= 1'b1;
                end
            end

            if (start_adc) begin
                frame_sr <= {2'b00, Ch0, 2'b00, Ch1, 2'b00};
                bit_cnt  <= '0;
            end

            if (adc_adv) begin
                frame_sr <= {frame_sr[FRAME_W-2:0], 1'b0};
                bit_cnt  <= bit_cnt + 1'b1;
            end
        end
    end

    // Both terms are flop outputs updated on the same edge, so MISO moves
    // exactly one clk after the capture or fall strobe and is forced low
    // whenever no frame is active.
    assign MISO = (state == ADC_FRAME) ? frame_sr[FRAME_W-1] : 1'b0;
    assign Busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_amp_adc_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_amp_adc_responder
// Purpose  : Self-checking bench for spi_amp_adc_responder with a queue-based
//            scoreboard and a behavioural reference for gain and frame data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_amp_adc_responder;

    import spi_periph_pkg::*;

    logic                clk      = 1'b0;
    logic                rst      = 1'b0;
    logic                SPI_CLK  = 1'b0;
    logic                MOSI     = 1'b0;
    logic                AMP_CS   = 1'b1;
    logic                ADC_Conv = 1'b0;
    logic [SAMPLE_W-1:0] Ch0      = '0;
    logic [SAMPLE_W-1:0] Ch1      = '0;
    logic                MISO;
    logic [GAIN_W-1:0]   Gain;
    logic                Gain_Valid;
    logic                Gain_Err;
    logic                Busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit               is_valid;
        logic [GAIN_W-1:0] gain;
    } gain_ev_t;

    gain_ev_t          gain_q[$];
    bit                exp_bits[$];
    bit                in_frame   = 1'b0;
    logic [GAIN_W-1:0] gain_model = '0;
    gain_ev_t          ev;
    bit                exp_bit;

    spi_amp_adc_responder dut (
        .clk        (clk),
        .rst        (rst),
        .SPI_CLK    (SPI_CLK),
        .MOSI       (MOSI),
        .AMP_CS     (AMP_CS),
        .ADC_Conv   (ADC_Conv),
        .Ch0        (Ch0),
        .Ch1        (Ch1),
        .MISO       (MISO),
        .Gain       (Gain),
        .Gain_Valid (Gain_Valid),
        .Gain_Err   (Gain_Err),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit i of the frame as seen by the controller, i = 0 first on the wire.
    function automatic bit frame_bit(input int c0, input int c1, input int i);
        if (i >= 2 && i <= SAMPLE_W + 1)
            return bit'((c0 >> (SAMPLE_W + 1 - i)) & 1);
        if (i >= SAMPLE_W + 4 && i <= 2 * SAMPLE_W + 3)
            return bit'((c1 >> (2 * SAMPLE_W + 3 - i)) & 1);
        return 1'b0;
    endfunction

    task automatic wait_drain(input string name);
        int n = 0;
        while (gain_q.size() != 0 && n < 20) begin
            tick(1);
            n++;
        end
        check(name, 32'(gain_q.size()), 32'd0);
        gain_q.delete();
        tick(4);
    endtask

    // Gain write of nbits bits; with_conv raises ADC_Conv together with the select fall.
    task automatic gain_write(input logic [7:0] val, input int nbits, input int half, input bit with_conv);
        AMP_CS = 1'b0;
        if (with_conv) begin
            ADC_Conv = 1'b1;
            tick(3);
            ADC_Conv = 1'b0;
            tick(5);
            check("collide_busy", 32'(Busy), 32'd1);
            check("collide_miso", 32'(MISO), 32'd0);
        end else begin
            tick(8);
        end
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 8) ? val[7 - i] : 1'($urandom_range(0, 1));
            tick(half);
            SPI_CLK = 1'b1;
            tick(half);
            SPI_CLK = 1'b0;
        end
        tick(half);
        AMP_CS = 1'b1;
        MOSI   = 1'b0;
        if (nbits == GAIN_BITS_REQ) begin
            gain_model = val;
            gain_q.push_back('{1'b1, val});
        end else begin
            gain_q.push_back('{1'b0, gain_model});
        end
        wait_drain("gain_pulse_seen");
    endtask

    // ADC frame; conv_at injects a conversion at that bit, rst_at resets before that bit.
    task automatic adc_frame(input logic [SAMPLE_W-1:0] c0, input logic [SAMPLE_W-1:0] c1,
                             input int half, input int conv_at, input int rst_at);
        Ch0 = c0;
        Ch1 = c1;
        for (int i = 0; i < FRAME_LEN; i++)
            exp_bits.push_back(frame_bit(int'(c0), int'(c1), i));
        ADC_Conv = 1'b1;
        tick(3);
        ADC_Conv = 1'b0;
        tick(8);
        // Sources change after capture; the frame must hold the captured values.
        Ch0 = ~c0;
        Ch1 = ~c1;
        check("frame_busy", 32'(Busy), 32'd1);
        in_frame = 1'b1;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (i == rst_at) begin
                rst = 1'b0;
                #1;
                check("rst_miso", 32'(MISO), 32'd0);
                check("rst_busy", 32'(Busy), 32'd0);
                check("rst_gain", 32'(Gain), 32'd0);
                in_frame   = 1'b0;
                exp_bits.delete();
                gain_q.delete();
                gain_model = '0;
                tick(3);
                rst = 1'b1;
                tick(8);
                return;
            end
            SPI_CLK = 1'b1;
            if (i == conv_at) ADC_Conv = 1'b1;
            tick(half);
            SPI_CLK  = 1'b0;
            ADC_Conv = 1'b0;
            tick(half);
        end
        in_frame = 1'b0;
        tick(4);
        check("end_busy", 32'(Busy), 32'd0);
        check("end_miso", 32'(MISO), 32'd0);
        check("frame_bits_left", 32'(exp_bits.size()), 32'd0);
        exp_bits.delete();
    endtask

    // MISO monitor: every controller sampling edge.
    always @(posedge SPI_CLK) begin
        if (in_frame) begin
            if (exp_bits.size() == 0) begin
                total++;
                bad++;
                $display("FAIL miso_extra: got %0b expected no frame bit at %0t", MISO, $time);
            end else begin
                exp_bit = exp_bits.pop_front();
                check("miso_bit", 32'(MISO), 32'(exp_bit));
            end
        end else begin
            check("miso_idle", 32'(MISO), 32'd0);
        end
    end

    // Gain pulse monitor.
    always @(negedge clk) begin
        if (rst && (Gain_Valid || Gain_Err)) begin
            if (gain_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL gain_pulse_unexpected: got valid=%0b err=%0b gain=%0h expected no pulse",
                         Gain_Valid, Gain_Err, Gain);
            end else begin
                ev = gain_q.pop_front();
                check("pulse_valid", 32'(Gain_Valid), 32'(ev.is_valid));
                check("pulse_err", 32'(Gain_Err), 32'(!ev.is_valid));
                check("gain_value", 32'(Gain), 32'(ev.gain));
            end
        end
    end

    initial begin
        int nb;
        tick(3);
        check("reset_miso", 32'(MISO), 32'd0);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_gain", 32'(Gain), 32'd0);
        check("reset_valid", 32'(Gain_Valid), 32'd0);
        check("reset_err", 32'(Gain_Err), 32'd0);
        rst = 1'b1;
        tick(10);

        gain_write(8'h11, 8, 6, 1'b0);
        gain_write(8'hA5, 7, 6, 1'b0);
        check("short_keeps_gain", 32'(Gain), 32'h11);

        adc_frame(14'h2AAA, 14'h1555, 6, -1, -1);
        adc_frame(14'($urandom), 14'($urandom), 7, 10, -1);
        gain_write(8'h3C, 8, 6, 1'b1);
        gain_write(8'hC3, 9, 6, 1'b0);
        gain_write(8'h00, 0, 6, 1'b0);

        adc_frame(14'($urandom), 14'($urandom), 6, -1, 20);
        adc_frame(14'($urandom), 14'($urandom), 6, -1, -1);
        adc_frame(14'h3FFF, 14'h0001, 6, -1, -1);

        for (int t = 0; t < 14; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                nb = ($urandom_range(0, 9) < 6) ? 8 : int'($urandom_range(0, 10));
                gain_write(8'($urandom), nb, int'($urandom_range(6, 9)), 1'b0);
            end else begin
                adc_frame(14'($urandom), 14'($urandom), int'($urandom_range(6, 9)), -1, -1);
            end
        end

        tick(20);
        check("final_gain_queue", 32'(gain_q.size()), 32'd0);
        check("final_gain", 32'(Gain), 32'(gain_model));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
